fpu_norm_round: RTL
===================

FPU_NORM_ROUND -- requirements
Module: fpu_norm_round

Interface
REQ-001 Parameter: BIAS, default 31, exponent bias of the packed output format.
REQ-002 Parameter: EXP_W, default 6, packed exponent field width.
REQ-003 Parameter: FRAC_W, default 25, packed fraction field width.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream raw result valid.
REQ-007 in_ready  output  1  block idle and able to accept a raw result.
REQ-008 in_sign  input  1  sign of the raw result.
REQ-009 in_exp  input  8  signed two's-complement unbiased exponent.
REQ-010 in_mant  input  29  unsigned raw mantissa: [28] carry, [27] hidden, [26:2] fraction, [1] guard, [0] sticky; value = in_mant/2^27 * 2^in_exp.
REQ-011 out_valid  output  1  packed result valid.
REQ-012 out_ready  input  1  downstream accepts the packed result.
REQ-013 data_out  output  32  packed result {sign[31], exp[30:25], frac[24:0]}.
REQ-014 status_out  output  4  [0] zero, [1] overflow, [2] underflow, [3] inexact.

Function
REQ-015 The block SHALL implement the FSM IDLE, NORM, ROUND, OUT; in_ready = (state==IDLE); out_valid = (state==OUT).
REQ-016 In IDLE, in_valid at a rising edge SHALL capture in_sign, in_exp (sign-extended to a 10-bit internal exponent) and in_mant, then go to NORM; if in_mant==0, go to OUT instead.
REQ-017 On a zero capture, data_out SHALL load {in_sign, 31'b0} and status_out SHALL load 4'b0001 at the capture edge.
REQ-018 NORM SHALL perform exactly one action per cycle: mant[28]=1 -> shift right 1, new mant[0] = old mant[1]|old mant[0], exp+1; else mant[27]=0 -> shift left 1, exp-1; else go to ROUND.
REQ-019 A non-zero input SHALL need at most 27 left shifts or 1 right shift; NORM SHALL NOT loop beyond this.
REQ-020 ROUND SHALL apply round-to-nearest-even: lsb=mant[2], guard=mant[1], sticky=mant[0]; round up iff guard & (sticky | lsb); round-up adds 1 at bit 2.
REQ-021 A rounding carry out of the fraction SHALL give mantissa 1.0 (fraction 0) and exp+1, in the same ROUND cycle.
REQ-022 inexact SHALL be guard|sticky evaluated before rounding.
REQ-023 biased = exp + BIAS, computed at internal width with no wrap.
REQ-024 biased >= 63: data_out = {sign, 6'h3F, 25'b0}; status = overflow|inexact.
REQ-025 biased <= 0: data_out = {sign, 31'b0}; status = zero|underflow|inexact.
REQ-026 Otherwise: data_out = {sign, biased[5:0], rounded fraction[24:0]}; status = {inexact, 3'b000}.
REQ-027 ROUND SHALL register data_out and status_out and go to OUT at the next edge.
REQ-028 Latency, capture edge to out_valid high: 2 + k cycles for k NORM shifts; zero input 1 cycle.
REQ-029 In OUT, data_out and status_out SHALL hold stable until out_valid & out_ready at a rising edge, then the FSM goes to IDLE.
REQ-030 in_ready SHALL be low in the OUT-exit cycle; no capture SHALL occur in the same cycle as output acceptance.
REQ-031 in_valid outside IDLE SHALL be ignored; upstream holds its data until in_ready.

Reset
REQ-032 reset low SHALL immediately force IDLE, data_out=0, status_out=0, out_valid=0, in_ready=1, and all internal registers to 0.
REQ-033 reset asserted mid-operation SHALL discard the in-flight value; no output SHALL be produced for it.

Verification
REQ-034 sign 0, exp 0, mant 29'h0800_0000 -> data_out 32'h3E00_0000, status 4'b0000, out_valid 2 cycles after capture.
REQ-035 exp 0, mant 29'h1000_0000 -> one right shift, data_out 32'h4000_0000, status 0, latency 3; mant 29'h0080_0000 -> 4 left shifts, data_out 32'h3600_0000, latency 6.
REQ-036 Tie cases: mant 29'h0800_0002 -> 32'h3E00_0000 (tie, even, no round-up); mant 29'h0800_0006 -> 32'h3E00_0002; both status 4'b1000.
REQ-037 Range cases: exp 32, mant 29'h0800_0000 -> 32'h7E00_0000, status 4'b1010; sign 1, exp -31 -> 32'h8000_0000, status 4'b1101; sign 1, mant 0 -> 32'h8000_0000, status 4'b0001, latency 1.
REQ-038 Back-pressure: out_ready held low 5 cycles in OUT -> data_out, status_out and out_valid stable, in_ready 0, new in_valid ignored.
REQ-039 Reset mid-operation: reset pulsed low during NORM -> all outputs 0 and in_ready 1 at once; the next capture completes normally.

Source files
------------

// File: rtl/fpu_norm_round.sv
`default_nettype none
// ============================================================================
// fpu_norm_round : serial normaliser and round-to-nearest-even packer
// Rev 1.0
// ============================================================================
module fpu_norm_round #(
    parameter int BIAS   = 31,
    parameter int EXP_W  = 6,
    parameter int FRAC_W = 25
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [7:0]              in_exp,
    input  logic [FRAC_W+3:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   data_out,
    output logic [3:0]              status_out
);

    localparam int c_EXP_INT_W = 10;
    localparam int c_MANT_W    = FRAC_W + 4;
    localparam logic signed [c_EXP_INT_W-1:0] c_EXP_MAX  = c_EXP_INT_W'((1 << EXP_W) - 1);
    localparam logic signed [c_EXP_INT_W-1:0] c_EXP_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                         r_state;
    logic                           r_sign;
    logic signed [c_EXP_INT_W-1:0]  r_exp;
    logic [c_MANT_W-1:0]            r_mant;

    logic                           w_up;
    logic                           w_inexact;
    logic [FRAC_W:0]                w_fsum;
    logic                           w_carry;
    logic signed [c_EXP_INT_W-1:0]  w_exp_r;
    logic signed [c_EXP_INT_W-1:0]  w_biased;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);

    // Hidden bit is always set in ROUND, so a carry out of the fraction means 10.0
    assign w_up      = r_mant[1] & (r_mant[0] | r_mant[2]);
    assign w_inexact = r_mant[1] | r_mant[0];
    assign w_fsum    = {1'b0, r_mant[FRAC_W+1:2]} + (FRAC_W+1)'(w_up);
    assign w_carry   = w_fsum[FRAC_W];
    assign w_exp_r   = r_exp + c_EXP_INT_W'(w_carry);
    assign w_biased  = w_exp_r + c_EXP_INT_W'(BIAS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= in_sign;
                        r_exp  <= {{(c_EXP_INT_W-8){in_exp[7]}}, in_exp};
                        r_mant <= in_mant;
                        if (in_mant == '0) begin
                            data_out   <= {in_sign, {(EXP_W+FRAC_W){1'b0}}};
                            status_out <= 4'b0001;
                            r_state    <= OUT;
                        end else begin
                            r_state    <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (r_mant[c_MANT_W-1]) begin
                        r_mant <= {1'b0, r_mant[c_MANT_W-1:2], r_mant[1] | r_mant[0]};
                        r_exp  <= r_exp + c_EXP_INT_W'(1);
                    end else if (!r_mant[c_MANT_W-2]) begin
                        r_mant <= {r_mant[c_MANT_W-2:0], 1'b0};
                        r_exp  <= r_exp - c_EXP_INT_W'(1);
                    end else begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    if (w_biased >= c_EXP_MAX) begin
                        data_out   <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        status_out <= 4'b1010;
                    end else if (w_biased <= c_EXP_ZERO) begin
                        data_out   <= {r_sign, {(EXP_W+FRAC_W){1'b0}}};
                        status_out <= 4'b1101;
                    end else begin
                        data_out   <= {r_sign, w_biased[EXP_W-1:0], w_fsum[FRAC_W-1:0]};
                        status_out <= {w_inexact, 3'b000};
                    end
                    r_state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
